// File: rtl/dcache_bus_ctrl.sv
// dcache_bus_ctrl: single-outstanding data-bus controller that stalls the Mem stage, aligns loads and builds store strobes/data
module dcache_bus_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Mem_DcacheEN,
  input  logic                  Mem_DcacheRd,
  input  logic [1:0]            Mem_DcacheWidth,
  input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
  input  logic                  Mem_DcacheSign,
  input  logic [DATA_WIDTH-1:0] Mem_StData,
  input  logic                  Csr_Memflush,
  output logic                  dbus_req_valid,
  input  logic                  dbus_req_ready,
  output logic                  dbus_req_we,
  output logic [ADDR_WIDTH-1:0] dbus_req_addr,
  output logic [DATA_WIDTH-1:0] dbus_req_wdata,
  output logic [7:0]            dbus_req_wstrb,
  input  logic                  dbus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dbus_rsp_rdata,
  input  logic                  dbus_rsp_err,
  output logic                  Dc_Stall,
  output logic [DATA_WIDTH-1:0] Dc_LdData,
  output logic                  Dc_LdValid,
  output logic                  Dc_Misalign,
  output logic                  Dc_BusErr
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state, state_nx;
  logic start, misal, sign;
  logic [1:0] width;
  logic [2:0] off;
  logic [DATA_WIDTH-1:0] sh, ld_ext, wdata_nx;
  logic [7:0] wstrb_nx;
  always_comb begin
    misal = Mem_DcacheWidth == 2'b01 ? Mem_DcacheAddr[0] :
            Mem_DcacheWidth == 2'b10 ? |Mem_DcacheAddr[1:0] :
            Mem_DcacheWidth == 2'b11 ? |Mem_DcacheAddr[2:0] : 1'b0;
    start = state == IDLE && Mem_DcacheEN && !Csr_Memflush;
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (misal ? DONE : REQ) : IDLE;
      REQ:     state_nx = dbus_req_ready ? RESP : REQ;
      RESP:    state_nx = dbus_rsp_valid ? DONE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    wdata_nx = Mem_DcacheWidth == 2'b00 ? {8{Mem_StData[7:0]}} :
               Mem_DcacheWidth == 2'b01 ? {4{Mem_StData[15:0]}} :
               Mem_DcacheWidth == 2'b10 ? {2{Mem_StData[31:0]}} : Mem_StData;
    wstrb_nx = (Mem_DcacheWidth == 2'b00 ? 8'h01 : Mem_DcacheWidth == 2'b01 ? 8'h03 :
                Mem_DcacheWidth == 2'b10 ? 8'h0F : 8'hFF) << Mem_DcacheAddr[2:0];
    sh = dbus_rsp_rdata >> {off, 3'b000};
    ld_ext = width == 2'b00 ? {{56{sign & sh[7]}}, sh[7:0]} :
             width == 2'b01 ? {{48{sign & sh[15]}}, sh[15:0]} :
             width == 2'b10 ? {{32{sign & sh[31]}}, sh[31:0]} : sh;
  end
  assign dbus_req_valid = state == REQ;
  assign Dc_Stall = start || state == REQ || state == RESP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dbus_req_we    <= 1'b0;
      dbus_req_addr  <= '0;
      dbus_req_wdata <= '0;
      dbus_req_wstrb <= '0;
      width          <= '0;
      sign           <= 1'b0;
      off            <= '0;
      Dc_LdData      <= '0;
      Dc_LdValid     <= 1'b0;
      Dc_Misalign    <= 1'b0;
      Dc_BusErr      <= 1'b0;
    end else begin
      state       <= state_nx;
      Dc_LdValid  <= 1'b0;
      Dc_BusErr   <= 1'b0;
      Dc_Misalign <= start && misal;
      if (start && !misal) begin
        dbus_req_we    <= !Mem_DcacheRd;
        dbus_req_addr  <= {Mem_DcacheAddr[ADDR_WIDTH-1:3], 3'b000};
        dbus_req_wdata <= wdata_nx;
        dbus_req_wstrb <= Mem_DcacheRd ? 8'h00 : wstrb_nx;
        width          <= Mem_DcacheWidth;
        sign           <= Mem_DcacheSign;
        off            <= Mem_DcacheAddr[2:0];
      end
      // An error clears the load result even for stores; successful stores leave it alone
      if (state == RESP && dbus_rsp_valid) begin
        Dc_BusErr  <= dbus_rsp_err;
        Dc_LdValid <= !dbus_rsp_err && !dbus_req_we;
        if (dbus_rsp_err || !dbus_req_we) Dc_LdData <= dbus_rsp_err ? '0 : ld_ext;
      end
    end
  end
endmodule
